spi_frame_writer: RTL and testbench
===================================

# spi_frame_writer

Consumes the 16-bit RGB565 words and word strobe produced by the SPI slave stage, moves them into the system clock domain, and writes them sequentially into a double-buffered frame RAM. Sits between the SPI slave and the HUB75 scan-out logic. Owns the write address, frame completion, bank swapping and abort on chip-select release, so the display side always reads a complete frame.

## Interface
- WIDTH, 64: panel columns (pixels per row).
- HEIGHT, 32: panel rows.
- ADDR_W, 11: width of the in-bank pixel address; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT.
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- spi_data  in  16  word from SPI slave; held stable by upstream for at least 4 clk cycles after spi_word_strobe rises.
- spi_word_strobe  in  1  SPI slave word-ready strobe (`pixel_clk`), asynchronous to clk.
- spi_cs_n  in  1  SPI chip select, asynchronous, active-low; deassertion marks end of transfer.
- wr_en  out  1  frame RAM write enable, one-cycle pulse.
- wr_addr  out  ADDR_W+1  {write bank, pixel index}.
- wr_data  out  16  pixel written.
- display_bank  out  1  bank the scan-out reads; always the complement of the write bank.
- frame_done  out  1  one-cycle pulse on frame completion.
- partial_frame  out  1  one-cycle pulse when a frame is aborted.

## Operation
- spi_word_strobe: two-flop synchroniser (reset 0) plus history flop; word event = sync2 & ~hist.
- spi_cs_n: two-flop synchroniser (reset 1) plus history flop; release event = sync2 & ~hist (0→1).
- On word event: register wr_data ← spi_data, wr_addr ← {wbank, pix}, wr_en ← 1, then pix ← pix+1.
- Last pixel (pix == WIDTH*HEIGHT-1) written: pix ← 0, wbank toggles, display_bank toggles, frame_done pulses in the same cycle as that write's wr_en.
- Release event with pix ≠ 0 (after any same-cycle increment): pix ← 0, bank unchanged, partial_frame pulses. With pix == 0: no action, no pulse.
- Simultaneous word and release events: the word is written first. If it completes the frame, only frame_done fires. Otherwise the pix reset follows and partial_frame fires.
- Words arriving while spi_cs_n is high are still written; chip select only gates aborts.
- pix arithmetic is unsigned ADDR_W bits and never exceeds WIDTH*HEIGHT-1.

## Timing
- Reset values: wr_en 0, wr_addr 0, wr_data 0, frame_done 0, partial_frame 0, wbank 0, display_bank 1, pix 0. All outputs are registered.
- Latency: if clk edge n is the first to sample spi_word_strobe high, wr_en is high for exactly the cycle following edge n+2. wr_data and wr_addr are valid in that same cycle.
- frame_done and partial_frame latency from the causing event matches wr_en's (3 edges).
- Strobe high and low phases must each last ≥ 2 clk cycles. Shorter pulses are undefined and need not be detected.
- Throughput: at most one write per 4 clk cycles, set by the strobe phase limit.
- display_bank changes on the edge that asserts frame_done and is stable otherwise.
- reset_n asserted mid-frame clears everything immediately, including synchronisers. The first strobe rise after release produces pix 0 in bank 0.

## Test plan
- WIDTH=4, HEIGHT=2: send 8 words 0x0001..0x0008 → wr_addr 0..7 with matching data, frame_done on the 8th write, display_bank 1→0.
- Send 8 more words 0x0100..0x0107 → wr_addr 8..15 (bank 1), frame_done, display_bank 0→1.
- Send 3 words, then raise spi_cs_n → partial_frame once, no frame_done, next word 0xABCD written at wr_addr 0 in the same bank.
- Raise spi_cs_n at pix 0 → no partial_frame. Make the 8th word's strobe and the cs release hit the same sync edge → frame_done only, next write at {new bank, 0}.
- Assert reset_n low after 5 words → all outputs at reset values. First word after release is written at wr_addr 0, display_bank 1.
- Strobe pulses high and low for 2 clk each, with a fixed count → one wr_en per pulse, none dropped, none duplicated.

Source files
------------

// File: rtl/spi_frame_writer.sv
// spi_frame_writer: brings RGB565 words from the SPI slave into the clk domain and
// writes them sequentially into a double-buffered frame RAM. It owns the pixel
// address, frame completion, bank swapping and the abort on chip-select release.
module spi_frame_writer #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       spi_data,
  input  logic              spi_word_strobe,
  input  logic              spi_cs_n,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [15:0]       wr_data,
  output logic              display_bank,
  output logic              frame_done,
  output logic              partial_frame
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(WIDTH * HEIGHT - 1);

  // strobe synchroniser idles low, chip-select synchroniser idles high (deselected)
  logic [1:0]        strb_sync_q;
  logic              strb_hist_q;
  logic [1:0]        cs_sync_q;
  logic              cs_hist_q;

  logic [ADDR_W-1:0] pix_q, pix_d;
  logic              wbank_q, wbank_d;
  logic              dbank_q, dbank_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              partial_q, partial_d;

  logic              word_ev;
  logic              rel_ev;

  assign word_ev = strb_sync_q[1] & ~strb_hist_q;
  assign rel_ev  = cs_sync_q[1] & ~cs_hist_q;

  // Synchronise the asynchronous strobe and chip select and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strb_sync_q <= 2'b00;
      strb_hist_q <= 1'b0;
      cs_sync_q   <= 2'b11;
      cs_hist_q   <= 1'b1;
    end else begin
      strb_sync_q <= {strb_sync_q[0], spi_word_strobe};
      strb_hist_q <= strb_sync_q[1];
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
      cs_hist_q   <= cs_sync_q[1];
    end
  end

  // Next-state: write the word first, then let a release abort whatever partial frame remains
  always_comb begin
    pix_d        = pix_q;
    wbank_d      = wbank_q;
    dbank_d      = dbank_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    partial_d    = 1'b0;
    if (word_ev) begin
      wr_en_d   = 1'b1;
      wr_addr_d = {wbank_q, pix_q};
      wr_data_d = spi_data;
      if (pix_q == LAST_PIX) begin
        pix_d        = '0;
        wbank_d      = ~wbank_q;
        dbank_d      = ~dbank_q;
        frame_done_d = 1'b1;
      end else begin
        pix_d = pix_q + ADDR_W'(1);
      end
    end
    // a frame completed by a same-cycle word leaves pix at 0, so no abort is reported
    if (rel_ev && (pix_d != '0)) begin
      pix_d     = '0;
      partial_d = 1'b1;
    end
  end

  // Register write state and all outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q        <= '0;
      wbank_q      <= 1'b0;
      dbank_q      <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      partial_q    <= 1'b0;
    end else begin
      pix_q        <= pix_d;
      wbank_q      <= wbank_d;
      dbank_q      <= dbank_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      partial_q    <= partial_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign display_bank  = dbank_q;
  assign frame_done    = frame_done_q;
  assign partial_frame = partial_q;

endmodule

// File: tb/tb_spi_frame_writer.sv
// Bench for spi_frame_writer on a 4x2 panel (8 pixels per bank).
module tb_spi_frame_writer;

  logic        clk;
  logic        reset_n;
  logic [15:0] spi_data;
  logic        spi_word_strobe;
  logic        spi_cs_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        display_bank;
  logic        frame_done;
  logic        partial_frame;

  spi_frame_writer #(.WIDTH(4), .HEIGHT(2), .ADDR_W(3)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .spi_data        (spi_data),
    .spi_word_strobe (spi_word_strobe),
    .spi_cs_n        (spi_cs_n),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .display_bank    (display_bank),
    .frame_done      (frame_done),
    .partial_frame   (partial_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic        done;
    logic        pf;
    logic        dbank;
  } wr_rec_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  addr;
    logic        done;
    logic        dbank;
  } vec_t;

  wr_rec_t wq[$];
  int      fd_cnt = 0;
  int      pf_cnt = 0;
  int      we_cnt = 0;
  int      n_chk  = 0;
  int      n_fail = 0;

  // capture every write and pulse away from the active edge
  always @(negedge clk) begin
    if (wr_en) begin
      wr_rec_t r;
      r.addr  = wr_addr;
      r.data  = wr_data;
      r.done  = frame_done;
      r.pf    = partial_frame;
      r.dbank = display_bank;
      wq.push_back(r);
      we_cnt++;
    end
    if (frame_done)    fd_cnt++;
    if (partial_frame) pf_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // caller is at a negedge; strobe high 2 clk then low 2 clk
  task automatic send_word(input logic [15:0] d, input logic rel);
    spi_data        = d;
    spi_word_strobe = 1'b1;
    if (rel) spi_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    spi_word_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_write(input string name, input logic [3:0] addr, input logic [15:0] data,
                              input logic done, input logic pf, input logic dbank);
    wr_rec_t r;
    for (int k = 0; k < 12 && wq.size() == 0; k++) @(negedge clk);
    if (wq.size() == 0) begin
      chk({name, " write timeout"}, 32'd0, 32'd1);
    end else begin
      r = wq.pop_front();
      chk({name, " addr"}, 32'(r.addr), 32'(addr));
      chk({name, " data"}, 32'(r.data), 32'(data));
      chk({name, " frame_done"}, 32'(r.done), 32'(done));
      chk({name, " partial"}, 32'(r.pf), 32'(pf));
      chk({name, " display_bank"}, 32'(r.dbank), 32'(dbank));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, " wr_en"}, 32'(wr_en), 32'd0);
    chk({name, " wr_addr"}, 32'(wr_addr), 32'd0);
    chk({name, " wr_data"}, 32'(wr_data), 32'd0);
    chk({name, " frame_done"}, 32'(frame_done), 32'd0);
    chk({name, " partial"}, 32'(partial_frame), 32'd0);
    chk({name, " display_bank"}, 32'(display_bank), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    int   pf0, fd0, we0;

    for (int i = 0; i < 8; i++) begin
      tbl[i].data  = 16'(i + 1);
      tbl[i].addr  = 4'(i);
      tbl[i].done  = (i == 7);
      tbl[i].dbank = (i == 7) ? 1'b0 : 1'b1;
    end
    for (int i = 8; i < 16; i++) begin
      tbl[i].data  = 16'h0100 + 16'(i - 8);
      tbl[i].addr  = 4'(i);
      tbl[i].done  = (i == 15);
      tbl[i].dbank = (i == 15) ? 1'b1 : 1'b0;
    end

    reset_n = 1'b0;
    spi_data = 16'h0;
    spi_word_strobe = 1'b0;
    spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // two full frames from the vector table
    pf0 = pf_cnt;
    for (int i = 0; i < 16; i++) begin
      send_word(tbl[i].data, 1'b0);
      expect_write($sformatf("vec%0d", i), tbl[i].addr, tbl[i].data, tbl[i].done, 1'b0, tbl[i].dbank);
    end
    chk("frames no partial", 32'(pf_cnt - pf0), 32'd0);

    // abort after three words
    fd0 = fd_cnt;
    send_word(16'h00A1, 1'b0); expect_write("ab0", 4'd0, 16'h00A1, 1'b0, 1'b0, 1'b1);
    send_word(16'h00A2, 1'b0); expect_write("ab1", 4'd1, 16'h00A2, 1'b0, 1'b0, 1'b1);
    send_word(16'h00A3, 1'b0); expect_write("ab2", 4'd2, 16'h00A3, 1'b0, 1'b0, 1'b1);
    pf0 = pf_cnt;
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort partial count", 32'(pf_cnt - pf0), 32'd1);
    chk("abort no frame_done", 32'(fd_cnt - fd0), 32'd0);
    chk("abort display_bank", 32'(display_bank), 32'd1);

    // release at pix 0 is silent
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    pf0 = pf_cnt;
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("release at pix0 no partial", 32'(pf_cnt - pf0), 32'd0);
    send_word(16'hABCD, 1'b0);
    expect_write("after abort", 4'd0, 16'hABCD, 1'b0, 1'b0, 1'b1);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);

    // last word and release on the same sync edge
    for (int i = 1; i < 7; i++) begin
      send_word(16'h00B0 + 16'(i), 1'b0);
      expect_write($sformatf("fill%0d", i), 4'(i), 16'h00B0 + 16'(i), 1'b0, 1'b0, 1'b1);
    end
    pf0 = pf_cnt;
    send_word(16'h00B7, 1'b1);
    expect_write("simul last", 4'd7, 16'h00B7, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("simul last no partial", 32'(pf_cnt - pf0), 32'd0);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_word(16'h00C0, 1'b0);
    expect_write("new bank", 4'd8, 16'h00C0, 1'b0, 1'b0, 1'b0);

    // mid-frame word with release: written, then aborted
    send_word(16'h00C1, 1'b1);
    expect_write("simul mid", 4'd9, 16'h00C1, 1'b0, 1'b1, 1'b0);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_word(16'h00C2, 1'b0);
    expect_write("after simul abort", 4'd8, 16'h00C2, 1'b0, 1'b0, 1'b0);

    // reset mid-frame
    for (int i = 0; i < 4; i++) begin
      send_word(16'h00D0 + 16'(i), 1'b0);
      expect_write($sformatf("pre-reset%0d", i), 4'(9 + i), 16'h00D0 + 16'(i), 1'b0, 1'b0, 1'b0);
    end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    send_word(16'h00E0, 1'b0);
    expect_write("post reset", 4'd0, 16'h00E0, 1'b0, 1'b0, 1'b1);

    // back-to-back minimum-phase burst
    we0 = we_cnt;
    for (int i = 0; i < 10; i++) send_word(16'h00F0 + 16'(i), 1'b0);
    repeat (6) @(negedge clk);
    chk("burst write count", 32'(we_cnt - we0), 32'd10);
    for (int i = 0; i < 10; i++) begin
      expect_write($sformatf("burst%0d", i), 4'(i + 1), 16'h00F0 + 16'(i),
                   (i == 6), 1'b0, (i < 6) ? 1'b1 : 1'b0);
    end
    chk("burst queue drained", 32'(wq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
